// File: rtl/mac_dot_seq.sv
// Dot-product sequencer for an external combinational MAC: streams (g,e) pairs into the MAC,
// keeps the running sum in a feedback register and emits one result per LEN accepted pairs.
module mac_dot_seq #(
  parameter int N     = 8,
  parameter int LEN   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     g_in,
  input  logic [N-1:0]     e_in,
  output logic [N-1:0]     mac_a,
  output logic [N-1:0]     mac_x,
  output logic [N-1:0]     mac_y0,
  input  logic [N-1:0]     mac_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [CNT_W-1:0] beat_idx
);

  typedef enum logic {ACC, HOLD} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  assign in_ready  = (state_q == ACC) && !flush;
  assign accept    = in_valid && in_ready;
  assign mac_a     = g_in;
  assign mac_x     = e_in;
  assign mac_y0    = acc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign beat_idx  = beat_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      // Abort wins over everything, including a pending result.
      state_d     = ACC;
      acc_d       = '0;
      beat_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (accept) begin
            if (beat_q == LAST) begin
              out_data_d  = mac_y;
              out_valid_d = 1'b1;
              acc_d       = '0;
              beat_d      = '0;
              state_d     = HOLD;
            end else begin
              acc_d  = mac_y;
              beat_d = beat_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      out_data_q  <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
